// File: rtl/irq_arbiter.sv
// Round-robin interrupt arbiter: edge-detected pending latches, software mask,
// valid/ack presentation and eoi-driven priority rotation.

module irq_lane (
   input  logic clk,
   input  logic reset,
   input  logic irq,
   input  logic clr,
   output logic pending
);
   logic irq_q;

   // A rise on the same edge as a clear wins, so a retrigger is never lost.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         irq_q   <= 1'b0;
         pending <= 1'b0;
      end else begin
         irq_q   <= irq;
         pending <= (pending & ~clr) | (irq & ~irq_q);
      end
   end
endmodule

module irq_arbiter #(
   parameter int N_IRQ = 4,
   parameter int ID_W  = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_IRQ-1:0] irq,
   input  logic             mask_we,
   input  logic [N_IRQ-1:0] mask_wdata,
   input  logic             irq_ack,
   input  logic             eoi,
   output logic             irq_valid,
   output logic [ID_W-1:0]  irq_id,
   output logic             busy,
   output logic [N_IRQ-1:0] pending,
   output logic [N_IRQ-1:0] mask
);
   typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

   state_t           state;
   logic [ID_W-1:0]  rr_ptr;
   logic [ID_W-1:0]  sel;
   logic             found;
   logic             ack_fire;
   logic [N_IRQ-1:0] clr;
   logic [N_IRQ-1:0] eligible;
   int               scan;

   assign ack_fire = (state == REQ) && irq_ack;
   assign eligible = pending & ~mask;

   for (genvar i = 0; i < N_IRQ; i++) begin : g_lane
      assign clr[i] = ack_fire && (irq_id == ID_W'(i));
      irq_lane u_lane (
         .clk     (clk),
         .reset   (reset),
         .irq     (irq[i]),
         .clr     (clr[i]),
         .pending (pending[i])
      );
   end

   // First eligible source at or above rr_ptr, wrapping past N_IRQ-1 to 0.
   always_comb begin
      found = 1'b0;
      sel   = '0;
      scan  = 0;
      for (int k = 0; k < N_IRQ; k++) begin
         scan = int'(rr_ptr) + k;
         if (scan >= N_IRQ) scan = scan - N_IRQ;
         if (!found && eligible[scan]) begin
            found = 1'b1;
            sel   = scan[ID_W-1:0];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         irq_valid <= 1'b0;
         irq_id    <= '0;
         busy      <= 1'b0;
         rr_ptr    <= '0;
         mask      <= '0;
      end else begin
         if (mask_we) mask <= mask_wdata;
         case (state)
            IDLE: if (found) begin
               irq_id    <= sel;
               irq_valid <= 1'b1;
               state     <= REQ;
            end
            REQ: if (irq_ack) begin
               irq_valid <= 1'b0;
               busy      <= 1'b1;
               state     <= SERVICE;
            end
            SERVICE: if (eoi) begin
               busy   <= 1'b0;
               rr_ptr <= (irq_id == ID_W'(N_IRQ - 1)) ? '0 : irq_id + 1'b1;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
